sc_statemachine_pointtype: RTL and testbench
============================================

Name: sc_statemachine_pointtype

Overview:
Control FSM sitting directly upstream of the point-type shift register. Converts debounced active-low player buttons (start, left, right) into the register's clear, load and shift-selection controls. Tracks the point's bit position so the point never wraps around the row edge. Produces a position bus for the display and scoring logic.

Parameters:
DATAWIDTH, 8, width of the driven point-type register (row length)
POS_WIDTH, 3, width of position bus; must satisfy 2^POS_WIDTH >= DATAWIDTH
INIT_POS, 3, bit index of the point after a load (must hold the single 1 of the loaded pattern)
REPEAT_CYCLES, 16, hold time in clocks before auto-repeat (used only with optional feature)

Ports:
SC_STATEMACHINEPOINTTYPE_CLOCK_50  in  1  system clock
SC_STATEMACHINEPOINTTYPE_RESET_InHigh  in  1  synchronous reset, active high
SC_STATEMACHINEPOINTTYPE_start_InLow  in  1  debounced start/new-point button, active low
SC_STATEMACHINEPOINTTYPE_left_InLow  in  1  debounced left button, active low
SC_STATEMACHINEPOINTTYPE_right_InLow  in  1  debounced right button, active low
SC_STATEMACHINEPOINTTYPE_clear_OutLow  out  1  to register clear input, active low
SC_STATEMACHINEPOINTTYPE_load0_OutLow  out  1  to register load input, active low
SC_STATEMACHINEPOINTTYPE_shiftselection_Out  out  2  01 = rotate left (toward MSB), 10 = rotate right, 00 = hold
SC_STATEMACHINEPOINTTYPE_position_OutBUS  out  POS_WIDTH  current bit index of the point
SC_STATEMACHINEPOINTTYPE_busy_Out  out  1  high in every state except IDLE

Behaviour:
- One clock. Reset is synchronous and active-high: sampled only on the rising clock edge; no asynchronous path.
- States: START, IDLE, LOAD, LEFT, RIGHT, WAITRELEASE. Moore outputs, decoded from the state register only.
- Reset: next edge -> state START, position = 0, loaded flag = 0.
- Reset output values (START): clear_OutLow = 0, load0_OutLow = 1, shiftselection = 00, busy = 1, position = 0.
- START: lasts exactly 1 cycle, then -> IDLE unconditionally.
- IDLE: all controls inactive (clear 1, load 1, shift 00), busy = 0.
- IDLE priority on the sampling edge:
  - start low -> LOAD.
  - else left low and right low -> WAITRELEASE; no shift.
  - else left low -> LEFT if loaded = 1 and position < DATAWIDTH-1; otherwise WAITRELEASE.
  - else right low -> RIGHT if loaded = 1 and position > 0; otherwise WAITRELEASE.
  - else stay in IDLE.
- LOAD: 1 cycle, load0_OutLow = 0. On exit: position = INIT_POS, loaded = 1, -> WAITRELEASE.
- LEFT: 1 cycle, shiftselection = 01. On exit: position +1, -> WAITRELEASE.
- RIGHT: 1 cycle, shiftselection = 10. On exit: position -1, -> WAITRELEASE.
- WAITRELEASE: outputs inactive, busy = 1. -> IDLE on the first edge that samples all three buttons high.
- Result: exactly one register action per press, regardless of hold length.
- Latency: button sampled low at edge k (in IDLE) -> control asserted for the cycle after edge k+1 -> downstream register updates at edge k+2. Position bus updates at the same edge k+2.
- Position never wraps: requests at an edge are consumed (state goes to WAITRELEASE) but issue no shift.
- A load while already loaded re-initialises position to INIT_POS.
- Reset asserted in any state, including mid-LEFT, mid-LOAD or mid-WAITRELEASE, overrides everything: next state START, position 0. A held button after START is treated as a fresh press once IDLE is reached.
- Unused state encodings -> START.

Optional Feature:
SC_STATEMACHINEPOINTTYPE_AUTOREPEAT_EN
- Defined: in WAITRELEASE, a counter of width ceil(log2(REPEAT_CYCLES+1)) counts while the same single direction button that caused entry stays low.
- On reaching REPEAT_CYCLES-1, the FSM re-evaluates as IDLE would (edge limits apply) and the counter clears.
- The counter clears on any button change and on reset. Load is never repeated.
- Undefined: counter absent; strictly one action per press.

Test Plan:
- Reset 2 cycles -> during START clear_OutLow=0 for exactly 1 cycle; then IDLE, busy=0, position=0.
- Right press before any load -> no shiftselection pulse, position stays 0, busy high until release.
- Start press, held 10 cycles -> load0_OutLow low exactly 1 cycle; position=3; no further load until start released.
- After load, left pressed 4 times -> 4 single-cycle 01 pulses, position 3->7; 5th left -> no pulse, position stays 7.
- Left and right low together in IDLE -> no shift; start+left together -> LOAD wins, position=3.
- Reset asserted during LEFT cycle -> next cycle START (clear low), position=0, shiftselection=00. With AUTOREPEAT_EN and REPEAT_CYCLES=16, right held 40 cycles from position 3 -> pulses at press and every 16 cycles held, stopping at position 0.

Source files
------------

// File: rtl/sc_statemachine_pointtype_if.sv
// Button and register-control bundle between the player buttons and the
// point-type FSM. The master side drives the buttons; the slave side is the FSM.
interface sc_statemachine_pointtype_if #(
   parameter int POS_WIDTH = 3
);
   logic                 SC_STATEMACHINEPOINTTYPE_start_InLow;
   logic                 SC_STATEMACHINEPOINTTYPE_left_InLow;
   logic                 SC_STATEMACHINEPOINTTYPE_right_InLow;
   logic                 SC_STATEMACHINEPOINTTYPE_clear_OutLow;
   logic                 SC_STATEMACHINEPOINTTYPE_load0_OutLow;
   logic [1:0]           SC_STATEMACHINEPOINTTYPE_shiftselection_Out;
   logic [POS_WIDTH-1:0] SC_STATEMACHINEPOINTTYPE_position_OutBUS;
   logic                 SC_STATEMACHINEPOINTTYPE_busy_Out;

   modport master (
      output SC_STATEMACHINEPOINTTYPE_start_InLow,
      output SC_STATEMACHINEPOINTTYPE_left_InLow,
      output SC_STATEMACHINEPOINTTYPE_right_InLow,
      input  SC_STATEMACHINEPOINTTYPE_clear_OutLow,
      input  SC_STATEMACHINEPOINTTYPE_load0_OutLow,
      input  SC_STATEMACHINEPOINTTYPE_shiftselection_Out,
      input  SC_STATEMACHINEPOINTTYPE_position_OutBUS,
      input  SC_STATEMACHINEPOINTTYPE_busy_Out
   );

   modport slave (
      input  SC_STATEMACHINEPOINTTYPE_start_InLow,
      input  SC_STATEMACHINEPOINTTYPE_left_InLow,
      input  SC_STATEMACHINEPOINTTYPE_right_InLow,
      output SC_STATEMACHINEPOINTTYPE_clear_OutLow,
      output SC_STATEMACHINEPOINTTYPE_load0_OutLow,
      output SC_STATEMACHINEPOINTTYPE_shiftselection_Out,
      output SC_STATEMACHINEPOINTTYPE_position_OutBUS,
      output SC_STATEMACHINEPOINTTYPE_busy_Out
   );
endinterface

// File: rtl/sc_statemachine_pointtype.sv
// Point-type control FSM: turns start/left/right presses into one clear/load/shift action each.
// Optional held-button auto-repeat is built when SC_STATEMACHINEPOINTTYPE_AUTOREPEAT_EN is defined.
module sc_statemachine_pointtype #(
   parameter int DATAWIDTH     = 8,
   parameter int POS_WIDTH     = 3,
   parameter int INIT_POS      = 3,
   parameter int REPEAT_CYCLES = 16
) (
   input  logic                        SC_STATEMACHINEPOINTTYPE_CLOCK_50,
   input  logic                        SC_STATEMACHINEPOINTTYPE_RESET_InHigh,
   sc_statemachine_pointtype_if.slave  if_pt
);
   typedef enum logic [2:0] {
      ST_START = 3'd0,
      ST_IDLE  = 3'd1,
      ST_LOAD  = 3'd2,
      ST_LEFT  = 3'd3,
      ST_RIGHT = 3'd4,
      ST_WAIT  = 3'd5
   } state_t;

   localparam logic [POS_WIDTH-1:0] LP_POS_MAX  = POS_WIDTH'(DATAWIDTH - 1);
   localparam logic [POS_WIDTH-1:0] LP_POS_INIT = POS_WIDTH'(INIT_POS);
   localparam logic [POS_WIDTH-1:0] LP_POS_ZERO = POS_WIDTH'(0);
   localparam logic [POS_WIDTH-1:0] LP_POS_ONE  = POS_WIDTH'(1);

   if (((32'd1 << POS_WIDTH) < DATAWIDTH) || (INIT_POS >= DATAWIDTH) || (REPEAT_CYCLES < 1))
   begin : g_param_check
      $error("sc_statemachine_pointtype: inconsistent parameters");
   end

   state_t               r_state;
   state_t               w_state_next;
   logic [2:0]           r_btn_n;      // {start, left, right}, sampled one edge earlier
   logic                 r_loaded;
   logic [POS_WIDTH-1:0] r_pos;
   logic                 r_clear_n;
   logic                 r_load_n;
   logic [1:0]           r_shift;
   logic                 r_busy;
   logic                 w_clear_n;
   logic                 w_load_n;
   logic [1:0]           w_shift;
   logic                 w_busy;
   logic                 w_rep_fire;

   // Decision taken from IDLE; edge limits turn a blocked move into a consumed press.
   function automatic state_t f_idle_eval(input logic [2:0] btn_n, input logic loaded,
                                          input logic [POS_WIDTH-1:0] pos);
      state_t nxt;
      if (!btn_n[2]) begin
         nxt = ST_LOAD;
      end else if (!btn_n[1] && !btn_n[0]) begin
         nxt = ST_WAIT;
      end else if (!btn_n[1]) begin
         nxt = (loaded && (pos < LP_POS_MAX)) ? ST_LEFT : ST_WAIT;
      end else if (!btn_n[0]) begin
         nxt = (loaded && (pos > LP_POS_ZERO)) ? ST_RIGHT : ST_WAIT;
      end else begin
         nxt = ST_IDLE;
      end
      return nxt;
   endfunction

`ifdef SC_STATEMACHINEPOINTTYPE_AUTOREPEAT_EN
   localparam int                  LP_CNT_W    = $clog2(REPEAT_CYCLES + 1);
   localparam logic [LP_CNT_W-1:0] LP_CNT_LAST = LP_CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [LP_CNT_W-1:0] LP_CNT_ONE  = LP_CNT_W'(1);

   logic [LP_CNT_W-1:0] r_rep_cnt;
   logic [1:0]          r_rep_dir;     // 2'b01 left, 2'b10 right, 2'b00 not repeatable
   logic                w_rep_hold;

   // Repeat qualifies only while the lone entry direction button stays low.
   always_comb begin
      w_rep_hold = 1'b0;
      if (r_state == ST_WAIT) begin
         case (r_rep_dir)
            2'b01:   w_rep_hold = (r_btn_n == 3'b101);
            2'b10:   w_rep_hold = (r_btn_n == 3'b110);
            default: w_rep_hold = 1'b0;
         endcase
      end else begin
         w_rep_hold = 1'b0;
      end
      w_rep_fire = w_rep_hold && (r_rep_cnt == LP_CNT_LAST);
   end

   // Hold counter and the direction that caused entry into WAITRELEASE.
   always_ff @(posedge SC_STATEMACHINEPOINTTYPE_CLOCK_50) begin
      if (SC_STATEMACHINEPOINTTYPE_RESET_InHigh) begin
         r_rep_cnt <= '0;
         r_rep_dir <= 2'b00;
      end else begin
         if (w_rep_hold && !w_rep_fire) begin
            r_rep_cnt <= r_rep_cnt + LP_CNT_ONE;
         end else begin
            r_rep_cnt <= '0;
         end
         if (r_state == ST_IDLE) begin
            case (r_btn_n)
               3'b101:  r_rep_dir <= 2'b01;
               3'b110:  r_rep_dir <= 2'b10;
               default: r_rep_dir <= 2'b00;
            endcase
         end
      end
   end
`else
   assign w_rep_fire = 1'b0;
`endif

   // Next-state logic.
   always_comb begin
      w_state_next = ST_START;
      case (r_state)
         ST_START: w_state_next = ST_IDLE;
         ST_IDLE:  w_state_next = f_idle_eval(r_btn_n, r_loaded, r_pos);
         ST_LOAD:  w_state_next = ST_WAIT;
         ST_LEFT:  w_state_next = ST_WAIT;
         ST_RIGHT: w_state_next = ST_WAIT;
         ST_WAIT: begin
            if (w_rep_fire) begin
               w_state_next = f_idle_eval(r_btn_n, r_loaded, r_pos);
            end else if (r_btn_n == 3'b111) begin
               w_state_next = ST_IDLE;
            end else begin
               w_state_next = ST_WAIT;
            end
         end
         default:  w_state_next = ST_START;
      endcase
   end

   // Moore output decode of the next state, registered alongside the state itself.
   always_comb begin
      w_clear_n = 1'b1;
      w_load_n  = 1'b1;
      w_shift   = 2'b00;
      w_busy    = 1'b1;
      case (w_state_next)
         ST_START: w_clear_n = 1'b0;
         ST_IDLE:  w_busy    = 1'b0;
         ST_LOAD:  w_load_n  = 1'b0;
         ST_LEFT:  w_shift   = 2'b01;
         ST_RIGHT: w_shift   = 2'b10;
         ST_WAIT:  w_busy    = 1'b1;
         default:  w_clear_n = 1'b0;
      endcase
   end

   // State register and registered outputs.
   always_ff @(posedge SC_STATEMACHINEPOINTTYPE_CLOCK_50) begin
      if (SC_STATEMACHINEPOINTTYPE_RESET_InHigh) begin
         r_state   <= ST_START;
         r_clear_n <= 1'b0;
         r_load_n  <= 1'b1;
         r_shift   <= 2'b00;
         r_busy    <= 1'b1;
      end else begin
         r_state   <= w_state_next;
         r_clear_n <= w_clear_n;
         r_load_n  <= w_load_n;
         r_shift   <= w_shift;
         r_busy    <= w_busy;
      end
   end

   // Button sampling and point position; the position moves as its action state is left.
   always_ff @(posedge SC_STATEMACHINEPOINTTYPE_CLOCK_50) begin
      if (SC_STATEMACHINEPOINTTYPE_RESET_InHigh) begin
         r_btn_n  <= 3'b111;
         r_loaded <= 1'b0;
         r_pos    <= LP_POS_ZERO;
      end else begin
         r_btn_n <= {if_pt.SC_STATEMACHINEPOINTTYPE_start_InLow,
                     if_pt.SC_STATEMACHINEPOINTTYPE_left_InLow,
                     if_pt.SC_STATEMACHINEPOINTTYPE_right_InLow};
         case (r_state)
            ST_LOAD: begin
               r_pos    <= LP_POS_INIT;
               r_loaded <= 1'b1;
            end
            ST_LEFT:  r_pos <= r_pos + LP_POS_ONE;
            ST_RIGHT: r_pos <= r_pos - LP_POS_ONE;
            default:  r_pos <= r_pos;
         endcase
      end
   end

   assign if_pt.SC_STATEMACHINEPOINTTYPE_clear_OutLow       = r_clear_n;
   assign if_pt.SC_STATEMACHINEPOINTTYPE_load0_OutLow       = r_load_n;
   assign if_pt.SC_STATEMACHINEPOINTTYPE_shiftselection_Out = r_shift;
   assign if_pt.SC_STATEMACHINEPOINTTYPE_position_OutBUS    = r_pos;
   assign if_pt.SC_STATEMACHINEPOINTTYPE_busy_Out           = r_busy;
endmodule

// File: tb/tb_sc_statemachine_pointtype.sv
// Bench for sc_statemachine_pointtype: directed test-plan steps then random button
// sequences, every cycle compared against a press/action reference model.
module tb_sc_statemachine_pointtype;
   localparam int DATAWIDTH = 8;
   localparam int POS_WIDTH = 3;
   localparam int INIT_POS  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   sc_statemachine_pointtype_if #(.POS_WIDTH(POS_WIDTH)) u_if ();

   sc_statemachine_pointtype #(
      .DATAWIDTH(DATAWIDTH), .POS_WIDTH(POS_WIDTH), .INIT_POS(INIT_POS), .REPEAT_CYCLES(16)
   ) u_dut (
      .SC_STATEMACHINEPOINTTYPE_CLOCK_50    (clk),
      .SC_STATEMACHINEPOINTTYPE_RESET_InHigh(rst),
      .if_pt                                (u_if)
   );

   always #5 clk = ~clk;

   // Model: m_pend is the register action being shown this cycle (0 none, 1 load, 2 left, 3 right).
   int         m_pos    = 0;
   bit         m_loaded = 1'b0;
   bit         m_start  = 1'b1;
   bit         m_lock   = 1'b0;
   int         m_pend   = 0;
   logic [2:0] m_seen   = 3'b111;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input logic [2:0] btn_n);
      if (r) begin
         m_pos = 0; m_loaded = 1'b0; m_start = 1'b1; m_lock = 1'b0; m_pend = 0;
         m_seen = 3'b111;
         return;
      end
      if (m_pend != 0) begin
         if (m_pend == 1) begin m_pos = INIT_POS; m_loaded = 1'b1; end
         else if (m_pend == 2) m_pos = m_pos + 1;
         else m_pos = m_pos - 1;
         m_pend = 0;
         m_lock = 1'b1;
      end else if (m_start) begin
         m_start = 1'b0;
      end else if (m_lock) begin
         if (m_seen == 3'b111) m_lock = 1'b0;
      end else begin
         if (!m_seen[2]) m_pend = 1;
         else if (!m_seen[1] && !m_seen[0]) m_lock = 1'b1;
         else if (!m_seen[1]) begin
            if (m_loaded && m_pos < DATAWIDTH - 1) m_pend = 2; else m_lock = 1'b1;
         end else if (!m_seen[0]) begin
            if (m_loaded && m_pos > 0) m_pend = 3; else m_lock = 1'b1;
         end
      end
      m_seen = btn_n;
   endtask

   // One clock: drive {start,left,right} (active low) and reset, then compare every output.
   task automatic tick(input logic [2:0] btn_n, input bit r);
      logic [1:0] exp_shift;
      u_if.SC_STATEMACHINEPOINTTYPE_start_InLow = btn_n[2];
      u_if.SC_STATEMACHINEPOINTTYPE_left_InLow  = btn_n[1];
      u_if.SC_STATEMACHINEPOINTTYPE_right_InLow = btn_n[0];
      rst = r;
      @(posedge clk);
      model_edge(r, btn_n);
      #1;
      exp_shift = (m_pend == 2) ? 2'b01 : (m_pend == 3) ? 2'b10 : 2'b00;
      chk("clear", 8'(u_if.SC_STATEMACHINEPOINTTYPE_clear_OutLow), 8'(!m_start));
      chk("load0", 8'(u_if.SC_STATEMACHINEPOINTTYPE_load0_OutLow), 8'(m_pend != 1));
      chk("shift", 8'(u_if.SC_STATEMACHINEPOINTTYPE_shiftselection_Out), 8'(exp_shift));
      chk("position", 8'(u_if.SC_STATEMACHINEPOINTTYPE_position_OutBUS), 8'(m_pos));
      chk("busy", 8'(u_if.SC_STATEMACHINEPOINTTYPE_busy_Out),
          8'(m_start || m_lock || (m_pend != 0)));
   endtask

   task automatic press(input logic [2:0] btn_n, input int hold);
      for (int i = 0; i < hold; i++) tick(btn_n, 1'b0);
      for (int i = 0; i < 3; i++) tick(3'b111, 1'b0);
   endtask

   initial begin
      int hold;
      logic [2:0] pat;
      u_if.SC_STATEMACHINEPOINTTYPE_start_InLow = 1'b1;
      u_if.SC_STATEMACHINEPOINTTYPE_left_InLow  = 1'b1;
      u_if.SC_STATEMACHINEPOINTTYPE_right_InLow = 1'b1;

      // Reset for two cycles, then settle in IDLE.
      tick(3'b111, 1'b1);
      tick(3'b111, 1'b1);
      tick(3'b111, 1'b0);
      tick(3'b111, 1'b0);
      chk("idle_pos", 8'(u_if.SC_STATEMACHINEPOINTTYPE_position_OutBUS), 8'd0);

      press(3'b110, 4);            // right before any load: consumed, no shift
      press(3'b011, 10);           // start held: one load, position 3
      chk("after_load", 8'(u_if.SC_STATEMACHINEPOINTTYPE_position_OutBUS), 8'd3);
      for (int i = 0; i < 5; i++) press(3'b101, 2);   // 4 lefts to 7, 5th blocked
      chk("left_edge", 8'(u_if.SC_STATEMACHINEPOINTTYPE_position_OutBUS), 8'd7);
      press(3'b100, 3);            // left+right together
      press(3'b001, 3);            // start+left: load wins
      chk("load_wins", 8'(u_if.SC_STATEMACHINEPOINTTYPE_position_OutBUS), 8'd3);

      // Reset landing while the FSM sits in LEFT.
      tick(3'b101, 1'b0);
      tick(3'b101, 1'b0);
      chk("in_left", 8'(u_if.SC_STATEMACHINEPOINTTYPE_shiftselection_Out), 8'd1);
      tick(3'b101, 1'b1);
      tick(3'b101, 1'b0);          // START with left still held
      press(3'b101, 3);            // held left seen fresh in IDLE, blocked (not loaded)

      press(3'b011, 1);
      for (int i = 0; i < 4; i++) press(3'b110, 2);   // right down to 0 then blocked

      // Random segments of held patterns, gaps and occasional resets.
      for (int s = 0; s < 120; s++) begin
         pat  = 3'($urandom_range(0, 7));
         hold = $urandom_range(1, 6);
         if ($urandom_range(0, 39) == 0) begin
            tick(pat, 1'b1);
         end else begin
            for (int i = 0; i < hold; i++) tick(pat, 1'b0);
            hold = $urandom_range(0, 3);
            for (int i = 0; i < hold; i++) tick(3'b111, 1'b0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
